// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: folded 16-tap FIR. One multiplier and one accumulator are
// shared across all taps and stepped through by a three-state FSM (IDLE/MAC/OUT).
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   sample handshake, in_data = x[n]
//   clear               history flush, honoured in IDLE only
//   coef_we/addr/data   coefficient bank write port (IDLE only)
//   coef_drop           one-cycle pulse when a coefficient write was discarded
//   out_valid/out_ready result handshake, out_data = y[n] (low N bits of the sum)
//   busy                high while in MAC or OUT
module fir_mac_sequencer #(
  parameter int unsigned N         = 16,
  parameter int unsigned TAPS      = 16,
  parameter int unsigned CW        = 6,
  parameter int unsigned COEF_INIT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  input  logic                    clear,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_data,
  output logic                    coef_drop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_data,
  output logic                    busy
);

  localparam int unsigned KW = $clog2(TAPS);
  localparam int unsigned PW = N + CW;
  // Wide enough for TAPS full-scale products, so the sum never wraps.
  localparam int unsigned AW = N + CW + KW;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [N-1:0]    r_hist [TAPS];
  logic [CW-1:0]   r_coef [TAPS];
  logic [AW-1:0]   r_acc;
  logic [KW-1:0]   r_k;
  logic [N-1:0]    r_out_data;
  logic            r_coef_drop;

  logic            w_accept;
  logic            w_last_tap;
  logic [PW-1:0]   w_prod;
  logic [AW-1:0]   w_acc_sum;

  assign in_ready   = (r_state == StIdle) & ~reset;
  assign w_accept   = in_valid & in_ready;
  assign w_last_tap = (r_k == KW'(TAPS - 1));
  assign w_prod     = PW'(r_hist[r_k]) * PW'(r_coef[r_k]);
  assign w_acc_sum  = r_acc + AW'(w_prod);

  assign out_valid  = (r_state == StOut);
  assign busy       = (r_state != StIdle);
  assign out_data   = r_out_data;
  assign coef_drop  = r_coef_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept)   w_state_next = StMac;
      StMac:   if (w_last_tap) w_state_next = StOut;
      StOut:   if (out_ready)  w_state_next = StIdle;
      default:                 w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= CW'(COEF_INIT);
      end
      r_acc       <= '0;
      r_k         <= '0;
      r_out_data  <= '0;
      r_coef_drop <= 1'b0;
    end else begin
      r_coef_drop <= coef_we & (r_state != StIdle);
      // A write on the accept edge lands before MAC reads the bank.
      if (coef_we && (r_state == StIdle)) begin
        r_coef[coef_addr] <= coef_data;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            for (int i = 1; i < int'(TAPS); i++) begin
              r_hist[i] <= clear ? '0 : r_hist[i-1];
            end
            r_hist[0] <= in_data;
            r_acc     <= '0;
            r_k       <= '0;
          end else if (clear) begin
            for (int i = 0; i < int'(TAPS); i++) begin
              r_hist[i] <= '0;
            end
          end
        end
        StMac: begin
          r_acc <= w_acc_sum;
          r_k   <= r_k + KW'(1);
          if (w_last_tap) begin
            r_out_data <= w_acc_sum[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
